// File: rtl/genesis_gamepad_pkg.sv
// Shared types and bit maps for the Genesis / Master System pad reader.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package genesis_gamepad_pkg;

  // Detected pad kind, as driven on oGENPAD_TYPE (2'b11 is never produced).
  typedef enum logic [1:0] {
    PAD_MS   = 2'b00,
    PAD_GEN3 = 2'b01,
    PAD_GEN6 = 2'b10
  } pad_type_e;

  // Bit positions inside oGENPAD_DECODED (active-high buttons).
  localparam int BTN_R = 0;
  localparam int BTN_L = 1;
  localparam int BTN_D = 2;
  localparam int BTN_U = 3;
  localparam int BTN_A = 4;
  localparam int BTN_B = 5;
  localparam int BTN_C = 6;
  localparam int BTN_S = 7;
  localparam int BTN_M = 8;
  localparam int BTN_X = 9;
  localparam int BTN_Y = 10;
  localparam int BTN_Z = 11;

  // Bit positions inside iGENPAD (active-low pad lines).
  localparam int PAD_RIGHT_MODE = 0;
  localparam int PAD_LEFT_X     = 1;
  localparam int PAD_DOWN_Y     = 2;
  localparam int PAD_UP_Z       = 3;
  localparam int PAD_B_A        = 4;
  localparam int PAD_C_START    = 5;

  localparam int PAD_W      = 6;
  localparam int BTN_W      = 12;
  localparam int NUM_PHASES = 8;

  // Button set laid out exactly like oGENPAD_DECODED (z is bit 11, r is bit 0).
  typedef struct packed {
    logic z, y, x, m, s, c, b, a, u, d, l, r;
  } buttons_t;

  // Pad kind from the phase-1 and phase-5 detections.
  function automatic pad_type_e pad_kind(input logic gen, input logic six);
    if (!gen)      return PAD_MS;
    else if (!six) return PAD_GEN3;
    else           return PAD_GEN6;
  endfunction

  // Mask the captured buttons down to what the detected pad actually reports.
  function automatic buttons_t pad_result(input logic gen, input logic six,
                                          input buttons_t cap);
    buttons_t res;
    res = cap;
    if (!(gen && six)) begin
      res.z = 1'b0;
      res.y = 1'b0;
      res.x = 1'b0;
      res.m = 1'b0;
    end
    // A Master System pad has no Start/A; its phase-1 lines are meaningless.
    if (!gen) begin
      res.s = 1'b0;
      res.a = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/genesis_gamepad_timer.sv
// Poll-start and phase-end strobe generator for the pad sequencer.
// Latency: poll_start every POLL_CYCLES; phase_end after STEP_CYCLES cycles of step_en.
// Backpressure: none; free-running, step counter restarts whenever step_en drops.
module genesis_gamepad_timer #(
  parameter int POLL_CYCLES = 833_333,
  parameter int STEP_CYCLES = 500
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic step_en,
  output logic poll_start,
  output logic phase_end
);

  localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

  logic [PW-1:0] poll_cnt;
  logic [SW-1:0] step_cnt;

  assign poll_start = (poll_cnt == POLL_LAST);
  assign phase_end  = step_en && (step_cnt == STEP_LAST);

  // Free-running poll period counter; wraps on the poll-start cycle.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)            poll_cnt <= '0;
    else if (poll_start) poll_cnt <= '0;
    else                 poll_cnt <= poll_cnt + 1'b1;
  end

  // Phase length counter; only runs while the sequencer is mid-poll.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)                       step_cnt <= '0;
    else if (!step_en || phase_end) step_cnt <= '0;
    else                            step_cnt <= step_cnt + 1'b1;
  end

endmodule

// File: rtl/genesis_gamepad.sv
// Genesis / Master System pad reader: 8-phase select sequence, detect and decode.
// Latency: results register one cycle after the phase-8 sample; held until the next poll.
// Backpressure: none. Optional 6-button support under macro GENPAD_SIX_BUTTON_EN.
module genesis_gamepad
  import genesis_gamepad_pkg::*;
#(
  parameter int POLL_CYCLES = 833_333,
  parameter int STEP_CYCLES = 500
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [PAD_W-1:0]  iGENPAD,
  output logic              oGENPAD_SELECT,
  output logic [1:0]        oGENPAD_TYPE,
  output logic [BTN_W-1:0]  oGENPAD_DECODED
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_POLL = 1'b1
  } state_e;

  logic [PAD_W-1:0] pad_meta, pad_sync;
  logic             poll_start, phase_end, step_en;

  state_e    state_q, state_d;
  logic [2:0] phase_q, phase_d;   // 0..7 stands for phases 1..8
  logic      sel_q, sel_d;
  logic      gen_q, gen_d;
  logic      six_q, six_d;
  buttons_t  cap_q, cap_d;
  pad_type_e type_q, type_d;
  buttons_t  dec_q, dec_d;

  assign step_en = (state_q == ST_POLL);

  genesis_gamepad_timer #(
    .POLL_CYCLES (POLL_CYCLES),
    .STEP_CYCLES (STEP_CYCLES)
  ) u_timer (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .step_en    (step_en),
    .poll_start (poll_start),
    .phase_end  (phase_end)
  );

  // Two-flop synchronizer; lines idle high so reset to released.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      pad_meta <= '1;
      pad_sync <= '1;
    end else begin
      pad_meta <= iGENPAD;
      pad_sync <= pad_meta;
    end
  end

  // Sequencer: advance phases on phase_end, capture samples, publish on phase 8.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    sel_d   = sel_q;
    gen_d   = gen_q;
    six_d   = six_q;
    cap_d   = cap_q;
    type_d  = type_q;
    dec_d   = dec_q;
    case (state_q)
      ST_IDLE: begin
        if (poll_start) begin
          state_d = ST_POLL;
          phase_d = 3'd0;
          sel_d   = 1'b0;
          gen_d   = 1'b0;
          six_d   = 1'b0;
          cap_d   = '0;
        end
      end
      ST_POLL: begin
        if (phase_end) begin
          case (phase_q)
            3'd0: begin
              gen_d   = (pad_sync[PAD_LEFT_X] == 1'b0) && (pad_sync[PAD_RIGHT_MODE] == 1'b0);
              cap_d.s = ~pad_sync[PAD_C_START];
              cap_d.a = ~pad_sync[PAD_B_A];
            end
            3'd1: begin
              cap_d.c = ~pad_sync[PAD_C_START];
              cap_d.b = ~pad_sync[PAD_B_A];
              cap_d.u = ~pad_sync[PAD_UP_Z];
              cap_d.d = ~pad_sync[PAD_DOWN_Y];
              cap_d.l = ~pad_sync[PAD_LEFT_X];
              cap_d.r = ~pad_sync[PAD_RIGHT_MODE];
            end
`ifdef GENPAD_SIX_BUTTON_EN
            3'd4: begin
              // A 6-button pad pulls all four direction lines low on this phase.
              six_d = gen_q && (pad_sync[PAD_UP_Z:PAD_RIGHT_MODE] == 4'b0000);
            end
            3'd5: begin
              if (six_q) begin
                cap_d.z = ~pad_sync[PAD_UP_Z];
                cap_d.y = ~pad_sync[PAD_DOWN_Y];
                cap_d.x = ~pad_sync[PAD_LEFT_X];
                cap_d.m = ~pad_sync[PAD_RIGHT_MODE];
              end
            end
`endif
            3'd7: begin
              type_d = pad_kind(gen_q, six_q);
              dec_d  = pad_result(gen_q, six_q, cap_q);
            end
            default: ;
          endcase
          if (phase_q == 3'd7) begin
            state_d = ST_IDLE;
            sel_d   = 1'b1;
          end else begin
            phase_d = phase_q + 3'd1;
            sel_d   = ~sel_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer and result registers; reset aborts any poll in flight.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= ST_IDLE;
      phase_q <= 3'd0;
      sel_q   <= 1'b1;
      gen_q   <= 1'b0;
      six_q   <= 1'b0;
      cap_q   <= '0;
      type_q  <= PAD_MS;
      dec_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      sel_q   <= sel_d;
      gen_q   <= gen_d;
      six_q   <= six_d;
      cap_q   <= cap_d;
      type_q  <= type_d;
      dec_q   <= dec_d;
    end
  end

  assign oGENPAD_SELECT  = sel_q;
  assign oGENPAD_TYPE    = type_q;
  assign oGENPAD_DECODED = dec_q;

endmodule

// File: tb/tb_genesis_gamepad.sv
// Directed bench for genesis_gamepad with behavioural MS / 3-button / 6-button pad models.
// Latency: a poll completes 8*S cycles after its select falls; results checked after that.
// Backpressure: n/a.
module tb_genesis_gamepad;

  localparam int P = 400;
  localparam int S = 20;

`ifdef GENPAD_SIX_BUTTON_EN
  localparam logic [1:0]  EXP6_TYPE = 2'b10;
  localparam logic [11:0] EXP6_DEC  = 12'h211;
`else
  localparam logic [1:0]  EXP6_TYPE = 2'b01;
  localparam logic [11:0] EXP6_DEC  = 12'h011;
`endif

  localparam int M_MS  = 0;
  localparam int M_3B  = 1;
  localparam int M_6B  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  pad;
  logic        sel;
  logic [1:0]  ptype;
  logic [11:0] dec;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  int          mode = M_MS;
  logic [5:0]  ms_lines = 6'b111111;
  logic [11:0] btn = 12'h000;   // active-high, same order as decoded
  int          fall_cnt = 0;
  int          high_cnt = 0;
  logic        sel_prev = 1'b1;

  genesis_gamepad #(
    .POLL_CYCLES (P),
    .STEP_CYCLES (S)
  ) dut (
    .iCLK            (clk),
    .iRST            (rst),
    .iGENPAD         (pad),
    .oGENPAD_SELECT  (sel),
    .oGENPAD_TYPE    (ptype),
    .oGENPAD_DECODED (dec)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pad-internal select-fall counter, cleared by a long select-high idle.
  always @(posedge clk) begin
    sel_prev <= sel;
    high_cnt <= sel ? high_cnt + 1 : 0;
    if (sel_prev && !sel)               fall_cnt <= fall_cnt + 1;
    else if (sel && high_cnt > 4 * S)   fall_cnt <= 0;
  end

  // Pad line model, active-low.
  always_comb begin
    pad = 6'b111111;
    if (mode == M_MS) begin
      pad = ms_lines;
    end else if (mode == M_6B && fall_cnt == 3) begin
      if (sel) pad = {~btn[6], ~btn[5], ~btn[11], ~btn[10], ~btn[9], ~btn[8]};
      else     pad = {~btn[7], ~btn[4], 4'b0000};
    end else if (mode == M_6B && fall_cnt == 4 && !sel) begin
      pad = {~btn[7], ~btn[4], 4'b1111};
    end else begin
      if (sel) pad = {~btn[6], ~btn[5], ~btn[3], ~btn[2], ~btn[1], ~btn[0]};
      else     pad = {~btn[7], ~btn[4], ~btn[3], ~btn[2], 2'b00};
    end
  end

  task automatic wait_fall(output bit ok);
    logic prev;
    ok = 1'b0;
    prev = sel;
    for (int i = 0; i < 3 * P; i++) begin
      @(negedge clk);
      if (prev === 1'b1 && sel === 1'b0) begin
        ok = 1'b1;
        break;
      end
      prev = sel;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL select_fall_timeout got no falling edge want one within %0d cycles", 3 * P);
    end
  endtask

  task automatic wait_poll;
    bit ok;
    wait_fall(ok);
    repeat (8 * S + 4) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (sel !== 1'b1) begin errors++; $display("FAIL reset_select got %b want 1", sel); end
    checks++;
    if (ptype !== 2'b00) begin errors++; $display("FAIL reset_type got %b want 00", ptype); end
    checks++;
    if (dec !== 12'h000) begin errors++; $display("FAIL reset_decoded got %h want 000", dec); end
    rst = 1'b0;
  endtask

  task automatic test_ms;
    mode = M_MS;
    ms_lines = 6'b101111;
    wait_poll();
    checks++;
    if (ptype !== 2'b00) begin errors++; $display("FAIL ms_type got %b want 00", ptype); end
    checks++;
    if (dec !== 12'b000000100000) begin errors++; $display("FAIL ms_decoded got %b want 000000100000", dec); end
  endtask

  task automatic test_gen3;
    mode = M_3B;
    btn = 12'h088;   // Start + Up
    wait_poll();
    checks++;
    if (ptype !== 2'b01) begin errors++; $display("FAIL gen3_type got %b want 01", ptype); end
    checks++;
    if (dec !== 12'b000010001000) begin errors++; $display("FAIL gen3_decoded got %b want 000010001000", dec); end
    checks++;
    if (dec[11:8] !== 4'b0000) begin errors++; $display("FAIL gen3_upper got %b want 0000", dec[11:8]); end
  endtask

  task automatic test_gen6;
    mode = M_6B;
    btn = 12'h211;   // X + A + Right
    wait_poll();
    checks++;
    if (ptype !== EXP6_TYPE) begin errors++; $display("FAIL gen6_type got %b want %b", ptype, EXP6_TYPE); end
    checks++;
    if (dec !== EXP6_DEC) begin errors++; $display("FAIL gen6_decoded got %b want %b", dec, EXP6_DEC); end
  endtask

  task automatic test_select_timing;
    bit   ok;
    int   last, edges;
    logic prev;
    for (int p = 0; p < 2; p++) begin
      wait_fall(ok);
      if (ok) begin
        last  = cyc;
        edges = 1;
        prev  = sel;
        for (int i = 0; i < 9 * S; i++) begin
          @(negedge clk);
          if (sel !== prev) begin
            edges++;
            prev = sel;
            checks++;
            if (cyc - last != S) begin
              errors++;
              $display("FAIL phase_len poll %0d edge %0d got %0d want %0d", p, edges, cyc - last, S);
            end
            last = cyc;
            if (p == 1 && edges == 5) begin
              checks++;
              if (ptype !== EXP6_TYPE) begin
                errors++;
                $display("FAIL type_at_edge5 got %b want %b", ptype, EXP6_TYPE);
              end
            end
          end
        end
        checks++;
        if (edges != 8) begin errors++; $display("FAIL select_edges poll %0d got %0d want 8", p, edges); end
        checks++;
        if (sel !== 1'b1) begin errors++; $display("FAIL select_idle poll %0d got %b want 1", p, sel); end
      end
    end
  endtask

  task automatic test_reset_midpoll;
    bit ok;
    int n;
    wait_fall(ok);
    repeat (3 * S + S / 2 - 1) @(negedge clk);
    checks++;
    if (sel !== 1'b1) begin errors++; $display("FAIL phase4_select got %b want 1", sel); end
    rst = 1'b1;
    #1;
    checks++;
    if (sel !== 1'b1) begin errors++; $display("FAIL midpoll_rst_select got %b want 1", sel); end
    checks++;
    if (ptype !== 2'b00) begin errors++; $display("FAIL midpoll_rst_type got %b want 00", ptype); end
    checks++;
    if (dec !== 12'h000) begin errors++; $display("FAIL midpoll_rst_decoded got %h want 000", dec); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 2 * P; i++) begin
      @(posedge clk);
      n++;
      #1;
      if (sel === 1'b0) break;
    end
    checks++;
    if (n != P) begin errors++; $display("FAIL first_poll_delay got %0d want %0d", n, P); end
    checks++;
    if (dec !== 12'h000) begin errors++; $display("FAIL aborted_poll_decoded got %h want 000", dec); end
    repeat (8 * S + 4) @(negedge clk);
    checks++;
    if (dec !== EXP6_DEC) begin errors++; $display("FAIL recover_decoded got %b want %b", dec, EXP6_DEC); end
  endtask

  initial begin
    test_reset();
    test_ms();
    test_gen3();
    test_gen6();
    test_select_timing();
    test_reset_midpoll();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
